// File: rtl/ped_pkg.sv
// Shared light encodings, pedestrian state type and light helpers.
// Imported by the traffic light FSM and the pedestrian crossing block.
package ped_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RED,
    WALK,
    FLASH
  } ped_state_t;

  function automatic logic is_onehot3(
    input logic [2:0] v
  );
    return (v == 3'b001) ||
           (v == 3'b010) ||
           (v == 3'b100);
  endfunction

endpackage

// File: rtl/ped_phase_timer.sv
// Loadable down-counter shared by the WALK and FLASH phases.
// Holds at zero; load has priority over counting.
module ped_phase_timer
  import ped_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller driven by the one-hot traffic light.
// Optional walk extension is enabled by defining PED_WALK_EXTEND_EN.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
  input  logic       ped_req,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash,
  output logic       req_pending,
  output logic       ped_served,
  output logic       conflict,
  output logic       err_illegal
);

  localparam logic [CNT_W-1:0] WALK_LD =
    CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LD =
    CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ped_state_t       state;
  logic [2:0]       light_q;
  logic             blink;
  logic             pend;

  logic [CNT_W-1:0] cnt;
  logic             zero;
  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_en;

  logic             red_edge;
  logic             green;
  logic             in_phase;
  logic             abort;
  logic             walk_done;
  logic             flash_done;
  logic             ext_hit;
  logic             next_pend;

  // Illegal encodings compare unequal to RED and GREEN by construction.
  assign red_edge   = (light == RED) && (light_q != RED);
  assign green      = (light == GREEN);
  assign in_phase   = (state == WALK) || (state == FLASH);
  assign flash_done = (state == FLASH) && zero;
  assign walk_done  = (state == WALK) && zero;
  // Last clearance cycle completes normally even if GREEN shows.
  assign abort      = in_phase && green && !flash_done;
  assign next_pend  = pend || ped_req;

`ifdef PED_WALK_EXTEND_EN
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(WALK_CYCLES / 2);
  logic ext_used;

  assign ext_hit = (state == WALK) && ped_req &&
                   !ext_used && (cnt < HALF);
`else
  assign ext_hit = 1'b0;
`endif

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    t_en   = 1'b0;
    if (abort) begin
      t_load = 1'b1;
    end else if ((state == WAIT_RED) && red_edge) begin
      t_load = 1'b1;
      t_val  = WALK_LD;
    end else if (ext_hit) begin
      t_load = 1'b1;
      t_val  = WALK_LD;
    end else if (walk_done) begin
      t_load = 1'b1;
      t_val  = FLASH_LD;
    end else if (in_phase) begin
      t_en = 1'b1;
    end
  end

  ped_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      light_q     <= RED;
      blink       <= 1'b0;
      pend        <= 1'b0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      flash       <= 1'b0;
      req_pending <= 1'b0;
      ped_served  <= 1'b0;
      conflict    <= 1'b0;
      err_illegal <= 1'b0;
`ifdef PED_WALK_EXTEND_EN
      ext_used    <= 1'b0;
`endif
    end else begin
      light_q    <= light;
      ped_served <= 1'b0;
      conflict   <= 1'b0;
      if (!is_onehot3(light)) begin
        err_illegal <= 1'b1;
      end

      if (abort) begin
        state       <= next_pend ? WAIT_RED : IDLE;
        req_pending <= next_pend;
        pend        <= 1'b0;
        walk        <= 1'b0;
        flash       <= 1'b0;
        dont_walk   <= 1'b1;
        blink       <= 1'b0;
        conflict    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ped_req) begin
              state       <= WAIT_RED;
              req_pending <= 1'b1;
            end
          end

          WAIT_RED: begin
            if (red_edge) begin
              state       <= WALK;
              walk        <= 1'b1;
              dont_walk   <= 1'b0;
              flash       <= 1'b0;
              req_pending <= 1'b0;
`ifdef PED_WALK_EXTEND_EN
              ext_used    <= 1'b0;
`endif
            end
          end

          WALK: begin
            if (ped_req && !ext_hit) begin
              pend        <= 1'b1;
              req_pending <= 1'b1;
            end
`ifdef PED_WALK_EXTEND_EN
            if (ext_hit) begin
              ext_used <= 1'b1;
            end
`endif
            if (walk_done && !ext_hit) begin
              state     <= FLASH;
              walk      <= 1'b0;
              flash     <= 1'b1;
              dont_walk <= 1'b1;
              blink     <= 1'b1;
              if (FLASH_CYCLES == 1) begin
                ped_served <= 1'b1;
              end
            end
          end

          FLASH: begin
            if (flash_done) begin
              state       <= next_pend ? WAIT_RED : IDLE;
              req_pending <= next_pend;
              pend        <= 1'b0;
              flash       <= 1'b0;
              dont_walk   <= 1'b1;
              blink       <= 1'b0;
            end else begin
              if (ped_req) begin
                pend        <= 1'b1;
                req_pending <= 1'b1;
              end
              blink     <= ~blink;
              dont_walk <= ~blink;
              // Registered pulse lands on the final clearance cycle.
              if (cnt == ONE) begin
                ped_served <= 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl.
// Uses WALK_CYCLES=4 and FLASH_CYCLES=4.
module tb_ped_crossing_ctrl;
  import ped_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] light;
  logic       ped_req;
  logic       walk;
  logic       dont_walk;
  logic       flash;
  logic       req_pending;
  logic       ped_served;
  logic       conflict;
  logic       err_illegal;

  int passed;
  int total;

  ped_crossing_ctrl #(
    .WALK_CYCLES  (4),
    .FLASH_CYCLES (4),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .ped_req     (ped_req),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .flash       (flash),
    .req_pending (req_pending),
    .ped_served  (ped_served),
    .conflict    (conflict),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ped_req = 1'b0;
    light   = RED;
    tick();
    tick();
    total++;
    if ({walk, dont_walk, flash, req_pending,
         ped_served, conflict, err_illegal}
        !== 7'b0100000)
      $display("FAIL reset_outputs: got %b expected %b",
        {walk, dont_walk, flash, req_pending,
         ped_served, conflict, err_illegal},
        7'b0100000);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_normal_grant();
    logic [15:0] e_walk;
    logic [15:0] e_flash;
    logic [15:0] e_dw;
    logic [15:0] e_ps;
    logic [15:0] e_rp;
    e_walk  = 16'h03C0;
    e_flash = 16'h3C00;
    e_dw    = 16'hD43F;
    e_ps    = 16'h2000;
    e_rp    = 16'h0038;
    for (int c = 0; c < 16; c++) begin
      tick();
      total++;
      if ({walk, flash, dont_walk, ped_served, req_pending}
          !== {e_walk[c], e_flash[c], e_dw[c],
               e_ps[c], e_rp[c]})
        $display("FAIL grant_c%0d: got %b expected %b", c,
          {walk, flash, dont_walk, ped_served, req_pending},
          {e_walk[c], e_flash[c], e_dw[c],
           e_ps[c], e_rp[c]});
      else passed++;
      total++;
      if ((walk && dont_walk) !== 1'b0)
        $display("FAIL grant_excl_c%0d: got 1 expected 0", c);
      else passed++;
      ped_req = (c == 2);
      light   = (c >= 5) ? RED : GREEN;
    end
    ped_req = 1'b0;
  endtask

  task automatic test_mid_red();
    logic seen;
    seen    = 1'b0;
    light   = GREEN;
    tick();
    light   = RED;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    total++;
    if (req_pending !== 1'b1)
      $display("FAIL same_edge_pending: got %b expected 1",
        req_pending);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (walk) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL mid_red_nowalk: got %b expected 0", seen);
    else passed++;
    light = YELLOW;
    tick();
    light = RED;
    tick();
    total++;
    if (walk !== 1'b1)
      $display("FAIL mid_red_walk: got %b expected 1", walk);
    else passed++;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if ({walk, dont_walk, flash, req_pending} !== 4'b0100)
      $display("FAIL mid_red_idle: got %b expected 0100",
        {walk, dont_walk, flash, req_pending});
    else passed++;
  endtask

  task automatic test_conflict();
    logic ps_seen;
    ps_seen = 1'b0;
    light   = GREEN;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    light = RED;
    tick();
    tick();
    total++;
    if (walk !== 1'b1)
      $display("FAIL conflict_walk2: got %b expected 1", walk);
    else passed++;
    light = GREEN;
    tick();
    total++;
    if ({walk, dont_walk, flash, conflict} !== 4'b0101)
      $display("FAIL conflict_abort: got %b expected 0101",
        {walk, dont_walk, flash, conflict});
    else passed++;
    tick();
    total++;
    if (conflict !== 1'b0)
      $display("FAIL conflict_pulse: got %b expected 0",
        conflict);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      if (ped_served) ps_seen = 1'b1;
      tick();
    end
    total++;
    if (ps_seen !== 1'b0)
      $display("FAIL conflict_served: got %b expected 0",
        ps_seen);
    else passed++;
  endtask

  task automatic test_pending();
    logic seen;
    seen    = 1'b0;
    light   = GREEN;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = RED;
    tick();
    total++;
    if ({walk, req_pending} !== 2'b10)
      $display("FAIL pend_grant: got %b expected 10",
        {walk, req_pending});
    else passed++;
    ped_req = 1'b1;
    tick();
    total++;
    if (req_pending !== 1'b1)
      $display("FAIL pend_set: got %b expected 1",
        req_pending);
    else passed++;
    ped_req = 1'b0;
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    tick();
    total++;
    if (ped_served !== 1'b1)
      $display("FAIL pend_served: got %b expected 1",
        ped_served);
    else passed++;
    tick();
    total++;
    if ({walk, dont_walk, flash, req_pending} !== 4'b0101)
      $display("FAIL pend_wait: got %b expected 0101",
        {walk, dont_walk, flash, req_pending});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (walk) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL pend_noedge: got %b expected 0", seen);
    else passed++;
    light = YELLOW;
    tick();
    light = RED;
    tick();
    total++;
    if (walk !== 1'b1)
      $display("FAIL pend_regrant: got %b expected 1", walk);
    else passed++;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if ({walk, req_pending} !== 2'b00)
      $display("FAIL pend_once: got %b expected 00",
        {walk, req_pending});
    else passed++;
    seen  = 1'b0;
    light = YELLOW;
    tick();
    light = RED;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (walk) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL pend_no_third: got %b expected 0", seen);
    else passed++;
  endtask

  task automatic test_illegal();
    total++;
    if (err_illegal !== 1'b0)
      $display("FAIL illegal_clear: got %b expected 0",
        err_illegal);
    else passed++;
    light = 3'b110;
    tick();
    light = GREEN;
    tick();
    total++;
    if (err_illegal !== 1'b1)
      $display("FAIL illegal_set: got %b expected 1",
        err_illegal);
    else passed++;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (err_illegal !== 1'b1)
      $display("FAIL illegal_sticky: got %b expected 1",
        err_illegal);
    else passed++;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = RED;
    tick();
    tick();
    total++;
    if (walk !== 1'b1)
      $display("FAIL rst_mid_walk: got %b expected 1", walk);
    else passed++;
    ped_req = 1'b1;
    reset   = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    reset = 1'b0;
    total++;
    if ({walk, dont_walk, req_pending, err_illegal}
        !== 4'b0100)
      $display("FAIL rst_mid_state: got %b expected 0100",
        {walk, dont_walk, req_pending, err_illegal});
    else passed++;
  endtask

`ifdef PED_WALK_EXTEND_EN
  task automatic test_extend();
    int wcount;
    wcount  = 0;
    light   = GREEN;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = RED;
    tick();
    for (int k = 1; k <= 10; k++) begin
      if (walk) wcount++;
      if (k == 4) begin
        total++;
        if (req_pending !== 1'b0)
          $display("FAIL ext_nopend: got %b expected 0",
            req_pending);
        else passed++;
      end
      if (k == 6) begin
        total++;
        if (req_pending !== 1'b1)
          $display("FAIL ext_second: got %b expected 1",
            req_pending);
        else passed++;
      end
      ped_req = (k == 3) || (k == 5);
      tick();
    end
    ped_req = 1'b0;
    total++;
    if (wcount !== 7)
      $display("FAIL ext_len: got %0d expected 7", wcount);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_normal_grant();
    test_mid_red();
    test_conflict();
    test_pending();
    test_illegal();
`ifdef PED_WALK_EXTEND_EN
    test_extend();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
Downstream consumer of the one-hot traffic light output (RED=3'b100, YELLOW=3'b010, GREEN=3'b001).
- Latches pedestrian button requests.
- Grants a WALK phase aligned to the start of a RED phase, then a flashing DONT_WALK clearance phase.
- Flags light conflicts and illegal light encodings.
- Drives the pedestrian signal head; all outputs are registered (Moore style).

Parameters:
- WALK_CYCLES, 8: cycles walk=1 is held per grant (>=1).
- FLASH_CYCLES, 6: cycles of flashing clearance (>=1).
- CNT_W, 8: phase counter width; must hold max(WALK_CYCLES, FLASH_CYCLES)-1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- light  in  3  one-hot traffic light from the upstream light FSM.
- ped_req  in  1  button request, level or pulse; sampled each cycle.
- walk  out  1  WALK lamp.
- dont_walk  out  1  DONT_WALK lamp; blinks during clearance.
- flash  out  1  high for the whole clearance phase.
- req_pending  out  1  request latched, not yet served.
- ped_served  out  1  one-cycle pulse at normal end of clearance.
- conflict  out  1  one-cycle pulse when a grant is aborted by GREEN.
- err_illegal  out  1  sticky: a non-one-hot light was sampled.

Behaviour:
- States: IDLE, WAIT_RED, WALK, FLASH. Internal registers: light_q (previous light), cnt[CNT_W], blink, pend.
- Reset values: state=IDLE, walk=0, dont_walk=1, flash=0, req_pending=0, ped_served=0, conflict=0, err_illegal=0, light_q=RED, cnt=0, pend=0.
- red_edge = (light==RED) && (light_q!=RED). light_q updates every cycle.
- IDLE:
  - ped_req=1 -> WAIT_RED; req_pending=1 next cycle.
  - A red_edge in the same cycle is ignored; the grant waits for the next edge.
- WAIT_RED:
  - red_edge -> WALK, cnt loaded with WALK_CYCLES-1.
  - walk=1 from the following cycle.
- WALK (walk=1, dont_walk=0, flash=0):
  - cnt decrements each cycle.
  - At cnt==0 -> FLASH, cnt loaded with FLASH_CYCLES-1, blink=1.
  - walk is high exactly WALK_CYCLES cycles.
- FLASH (walk=0, flash=1, dont_walk=blink):
  - blink toggles every cycle, starting at 1; cnt decrements.
  - At cnt==0: ped_served pulses; go to WAIT_RED if pend else IDLE.
  - pend clears; req_pending follows the new state.
- ped_req during WALK or FLASH sets pend; req_pending stays 1. Multiple requests collapse into one.
- light==GREEN sampled in WALK or FLASH:
  - Next cycle: state=IDLE (or WAIT_RED if pend), walk=0, dont_walk=1, flash=0, conflict pulses 1 cycle, no ped_served.
- YELLOW during WALK/FLASH is not a conflict.
- Illegal light (not exactly one bit set):
  - err_illegal=1 from the next cycle until reset.
  - The value is treated as not-RED and not-GREEN for all decisions; light_q still captures it.
- reset mid-phase: all state returns to reset values on the next edge; a pending request is discarded.
- Outputs never assert walk and dont_walk together. walk=1 implies flash=0.

Optional Feature:
- Macro: PED_WALK_EXTEND_EN.
- With the macro defined:
  - ped_req during WALK when cnt < WALK_CYCLES/2 reloads cnt to WALK_CYCLES-1.
  - This is allowed once per WALK phase (tracked by an ext_used flag cleared on entering WALK).
  - That request does not set pend. Later requests in the same WALK set pend as normal.
- Without the macro: every ped_req in WALK sets pend; no extension logic is present.

Decomposition:
- Package ped_pkg:
  - light encoding constants RED/YELLOW/GREEN, shared with the traffic light FSM.
  - state enum typedef (IDLE, WAIT_RED, WALK, FLASH).
  - helper function is_onehot3.
- One sub-module: ped_phase_timer. It is a loadable down-counter (load, load_val, en, outputs cnt and zero) instantiated once and reused for the WALK and FLASH durations.

Test Plan:
- Reset check: assert reset 2 cycles -> walk=0, dont_walk=1, flash=0, req_pending=0, err_illegal=0.
- Normal grant (WALK_CYCLES=4, FLASH_CYCLES=4):
  - Stimulus: light=GREEN; ped_req pulse at cycle 2; light=RED at cycle 5.
  - Response: req_pending=1 from cycle 3; walk=1 cycles 6-9; flash=1 cycles 10-13 with dont_walk 1,0,1,0; ped_served pulse at cycle 13; IDLE with dont_walk=1 at cycle 14.
- Mid-phase RED: light already RED when ped_req arrives -> no walk until light goes YELLOW/GREEN then RED again (new red_edge).
- Conflict abort: light=GREEN at the second WALK cycle -> next cycle walk=0, dont_walk=1, conflict=1 for exactly 1 cycle, ped_served never pulses.
- Pending and illegal:
  - 3 ped_req pulses during WALK -> after clearance, returns to WAIT_RED once; one further grant on the next red_edge.
  - light=3'b110 -> err_illegal=1 next cycle and stays 1 until reset.
- Extension (PED_WALK_EXTEND_EN, WALK_CYCLES=4):
  - ped_req at cnt=1 -> walk lasts 7 cycles total.
  - A second ped_req in the same WALK does not extend and sets req_pending.
